ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands and funct3 of the instruction currently held in the ID/EX register. It stalls the front of the pipeline while it computes, then hands a 32-bit result to the EX result mux for the EX/MEM register. The ALU covers every RV32I op; this block covers only the eight M-extension ops.

---
 rtl/ex_muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage.
// 32-cycle shift-add multiply or restoring divide; stalls the pipe.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [5:0]        cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              rneg_q;
  logic [XLEN-1:0]   dvsr;
  logic [2*XLEN-1:0] acc;

  logic            a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0, ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            accept, last;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fin_res;

  // Issue-side decode: signedness, magnitudes and fast-path detection.
  always_comb begin
    a_sgn = ~op[0] | (op == 3'b001);
    b_sgn = (op[2:1] == 2'b00 & ~op[1]) | (op[2] & ~op[0]);
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    div0  = (b == '0);
    ovf   = ~op[0]
          & (a == {1'b1, {(XLEN-1){1'b0}}})
          & (b == {XLEN{1'b1}});
    fast  = op[2] & (div0 | ovf);
    fast_res = '0;
    unique case (1'b1)
      div0 & ~op[1]: fast_res = {XLEN{1'b1}};
      div0 &  op[1]: fast_res = a;
      ~div0 & ~op[1]: fast_res = {1'b1, {(XLEN-1){1'b0}}};
      ~div0 &  op[1]: fast_res = '0;
    endcase
  end

  // One iteration of shift-add or restoring divide, plus sign fix.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
            + (acc[0] ? {1'b0, dvsr} : '0);
    mul_nx  = {mul_sum, acc[XLEN-1:1]};
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, dvsr};
    div_nx  = diff[XLEN]
            ? {acc[2*XLEN-2:0], 1'b0}
            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_nx  = op_q[2] ? div_nx : mul_nx;
    prod    = neg_q ? -acc_nx : acc_nx;
    quo     = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem     = rneg_q ? -acc_nx[2*XLEN-1:XLEN]
                     : acc_nx[2*XLEN-1:XLEN];
    fin_res = '0;
    unique case (1'b1)
      ~op_q[2] & (op_q[1:0] == 2'b00): fin_res = prod[XLEN-1:0];
      ~op_q[2] & (op_q[1:0] != 2'b00): fin_res = prod[2*XLEN-1:XLEN];
      op_q[2] & ~op_q[1]:              fin_res = quo;
      op_q[2] &  op_q[1]:              fin_res = rem;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic and handshake outputs; busy is combinational.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    last     = (cnt == 6'd31);
    unique case (state)
      IDLE: begin
        if (start && !flush) begin
          accept   = 1'b1;
          busy     = 1'b1;
          state_nx = fast ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (flush)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dvsr   <= '0;
      acc    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q   <= op;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dvsr   <= b_mag;
      acc    <= {{XLEN{1'b0}}, a_mag};
      cnt    <= '0;
      if (fast) result <= fast_res;
    end else if (state == CALC && !flush) begin
      acc <= acc_nx;
      cnt <= cnt + 6'd1;
      if (last) result <= fin_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed + random checks of the RV32M unit
// against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res = '0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, t;
    logic [63:0] p;
    logic [63:0] ux, uy;
    logic ov;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        t = sx / sy; return t[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (ov) return 32'h0;
        t = sx % sy; return t[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  // Issue in the current cycle, hold start until done, then idle one cycle.
  task automatic do_op(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input string tag);
    logic [31:0] exp;
    int lat, n;
    bit fst;
    exp = model(o, x, y);
    fst = o[2] && (y == 0 ||
          (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    lat = fst ? 1 : 33;
    start = 1'b1; op = o; a = x; b = y; flush = 1'b0;
    #1 chk({tag, ".busy_issue"}, busy, 1);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk); #1;
      if (done || !busy) break;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".result"}, result, exp);
    chk({tag, ".busy_at_done"}, busy, 0);
    start = 1'b0;
    last_res = exp;
    @(negedge clk); #1;
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    @(negedge clk); #1;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.result", result, 0);
    rst = 1'b1;
    @(negedge clk);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_neg");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    do_op(3'd5, 32'd100, 32'd7, "divu");
    do_op(3'd7, 32'd100, 32'd7, "remu");
    do_op(3'd4, 32'd5, 32'd0, "div0");
    do_op(3'd7, 32'd5, 32'd0, "remu0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Flush a DIVU in its tenth CALC cycle, then issue a MUL.
    start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7;
    #1 chk("flush.busy_issue", busy, 1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush.busy_calc", busy, 1);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush.busy_after", busy, 0);
    chk("flush.no_done", done, 0);
    chk("flush.result_kept", result, last_res);
    do_op(3'd0, 32'd3, 32'd4, "mul_after_flush");

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    repeat (5) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("areset.busy", busy, 0);
    chk("areset.done", done, 0);
    chk("areset.result", result, 0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    do_op(3'd0, 32'd2, 32'd3, "mul_after_reset");

    // Randomized operations, including zero divisors and overflow.
    for (int i = 0; i < 48; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      do_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
